cnt_tracker: RTL

Synthesizable observer for the up/down counter interface. It samples a counter's output word on a qualifying strobe and recovers the count direction that the counter's `ctrl` input must have had. It flags any sample that is not a legal single step and keeps saturating statistics. It sits on the consumer side of an up/down counter and checks or decodes the value stream in-system rather than only in a bench.

---
 rtl/cnt_tracker_if.sv | 24 ++
 rtl/cnt_tracker.sv | 116 +++++++++++
 2 files changed

// File: rtl/cnt_tracker_if.sv
// Bus between an up/down counter's consumer side and the cnt_tracker observer.
// The master drives samples and reads back the recovered direction and statistics.
interface cnt_tracker_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAT_W = 16
);
   logic [WIDTH-1:0]  cnt_in;
   logic              cnt_vld;
   logic              dir;
   logic              dir_vld;
   logic              step_err;
   logic [STAT_W-1:0] err_cnt;
   logic [STAT_W-1:0] turn_cnt;

   modport master (
      output cnt_in, cnt_vld,
      input  dir, dir_vld, step_err, err_cnt, turn_cnt
   );

   modport slave (
      input  cnt_in, cnt_vld,
      output dir, dir_vld, step_err, err_cnt, turn_cnt
   );
endinterface

// File: rtl/cnt_tracker.sv
// Observes an up/down counter's output stream, recovers its count direction,
// flags illegal steps and keeps saturating error and reversal statistics.
module cnt_tracker #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAT_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   cnt_tracker_if.slave   bus_if
);

   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_LOCK} state_e;
   typedef enum logic [1:0] {STEP_HOLD, STEP_UP, STEP_DOWN, STEP_BAD} step_e;

   localparam logic [STAT_W-1:0] STAT_MAX = '1;
   localparam logic [WIDTH-1:0]  DIFF_UP  = WIDTH'(1);
   localparam logic [WIDTH-1:0]  DIFF_DN  = '1;

   state_e            state_q;
   logic [WIDTH-1:0]  prev_q;
   logic              dir_q;
   logic              dir_vld_q;
   logic              step_err_q;
   logic [STAT_W-1:0] err_cnt_q;
   logic [STAT_W-1:0] turn_cnt_q;

   logic [STAT_W-1:0] err_cnt_d;
   logic [STAT_W-1:0] turn_cnt_d;
   logic [WIDTH-1:0]  diff;
   step_e             step;

   // Modulo difference makes wrap-around steps classify as ordinary UP/DOWN.
   always_comb begin
      diff = bus_if.cnt_in - prev_q;
      step = STEP_BAD;
      if (diff == '0)
         step = STEP_HOLD;
      else if (diff == DIFF_UP)
         step = STEP_UP;
      else if (diff == DIFF_DN)
         step = STEP_DOWN;

      err_cnt_d  = (err_cnt_q  == STAT_MAX) ? err_cnt_q  : err_cnt_q  + STAT_W'(1);
      turn_cnt_d = (turn_cnt_q == STAT_MAX) ? turn_cnt_q : turn_cnt_q + STAT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         prev_q     <= '0;
         dir_q      <= 1'b0;
         dir_vld_q  <= 1'b0;
         step_err_q <= 1'b0;
         err_cnt_q  <= '0;
         turn_cnt_q <= '0;
      end else begin
         step_err_q <= 1'b0;
         if (bus_if.cnt_vld) begin
            prev_q <= bus_if.cnt_in;
            unique case (state_q)
               ST_IDLE: state_q <= ST_ARM;
               ST_ARM: begin
                  unique case (step)
                     STEP_UP: begin
                        state_q   <= ST_LOCK;
                        dir_vld_q <= 1'b1;
                        dir_q     <= 1'b1;
                     end
                     STEP_DOWN: begin
                        state_q   <= ST_LOCK;
                        dir_vld_q <= 1'b1;
                        dir_q     <= 1'b0;
                     end
                     STEP_BAD: begin
                        step_err_q <= 1'b1;
                        err_cnt_q  <= err_cnt_d;
                     end
                     default: ;
                  endcase
               end
               ST_LOCK: begin
                  unique case (step)
                     STEP_UP: if (!dir_q) begin
                        dir_q      <= 1'b1;
                        turn_cnt_q <= turn_cnt_d;
                     end
                     STEP_DOWN: if (dir_q) begin
                        dir_q      <= 1'b0;
                        turn_cnt_q <= turn_cnt_d;
                     end
                     // Losing lock keeps the last direction for debug visibility.
                     STEP_BAD: begin
                        state_q    <= ST_ARM;
                        dir_vld_q  <= 1'b0;
                        step_err_q <= 1'b1;
                        err_cnt_q  <= err_cnt_d;
                     end
                     default: ;
                  endcase
               end
               default: begin
                  state_q   <= ST_IDLE;
                  dir_vld_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus_if.dir      = dir_q;
   assign bus_if.dir_vld  = dir_vld_q;
   assign bus_if.step_err = step_err_q;
   assign bus_if.err_cnt  = err_cnt_q;
   assign bus_if.turn_cnt = turn_cnt_q;

endmodule
